pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline controller for the five-stage ARM core. It holds a shadow scoreboard of the instructions in EXE, MEM and WB. From that state it drives the freeze and flush inputs of the IF/ID and ID/EX pipeline registers, and the operand-forwarding selects for the EXE stage. It also freezes the whole pipeline while a data-memory access waits for its SRAM acknowledge.

## Interface
Parameters:
- CNT_W, 16, width of the saturating hazard-stall counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_src1 / id_src2  in  4  source register numbers of the instruction in ID
- id_has_src1 / id_has_src2  in  1  source actually read
- id_wb_en, id_mem_r_en  in  1  ID instruction writes back / is a load
- id_wb_dest  in  4  ID destination register
- exe_branch_taken  in  1  branch resolved taken in EXE
- mem_access_req  in  1  MEM-stage instruction performs a load/store this cycle
- mem_ready  in  1  SRAM completes the access this cycle
- freeze_front  out  1  hold PC and IF/ID register
- flush_if_id  out  1  clear IF/ID register
- flush_id_ex  out  1  insert bubble into ID/EX register (its flush input)
- freeze_pipe  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- fwd_sel_a / fwd_sel_b  out  2  EXE operand select: 00 register file, 01 from MEM stage, 10 from WB stage
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Scoreboard entry per stage (EX, MEM, WB): valid, wb_en, mem_r, dest, src1, has1, src2, has2.
- Advance (shift ID→EX→MEM→WB) on every clock where freeze_pipe=0.
  - EX captures the ID fields, or a bubble (valid=0) when flush_id_ex=1.
- Memory FSM:
  - States MEM_IDLE and MEM_WAIT.
  - MEM_IDLE→MEM_WAIT when mem_access_req=1 and mem_ready=0.
  - MEM_WAIT→MEM_IDLE when mem_ready=1.
  - freeze_pipe = mem_access_req & ~mem_ready, in either state.
  - In MEM_WAIT, mem_access_req must stay high. If it drops, the FSM returns to MEM_IDLE (protocol violation, bench assertion).
- Hazard detect (ID vs. in-flight), match = has_srcN & (srcN == entry.dest) for either source:
  - With FORWARDING_EN: stall = EX.valid & EX.wb_en & EX.mem_r & match (load-use only).
  - Without FORWARDING_EN: stall = match against (EX.valid & EX.wb_en) or (MEM.valid & MEM.wb_en).
- Priority of output decisions, highest first:
  - rst: all outputs 0.
  - freeze_pipe: freeze_front=1, and both flushes are forced to 0.
  - exe_branch_taken: flush_if_id=1, flush_id_ex=1, freeze_front=0, and any stall is ignored.
  - stall: freeze_front=1, flush_id_ex=1.
  - Otherwise everything is 0.
- While frozen, exe_branch_taken stays asserted because EXE is held. The flush issues on the first unfrozen cycle.
- Forwarding, for each EX source:
  - Select 01 if MEM.valid & MEM.wb_en & MEM.dest==src.
  - Otherwise select 10 if WB.valid & WB.wb_en & WB.dest==src.
  - Otherwise select 00.
  - MEM has priority over WB.
  - A source with has=0 always selects 00.
- stall_cnt increments on each cycle with stall=1 that is not overridden by freeze or branch. It saturates at all-ones.

## Timing
- All outputs are combinational from scoreboard state and current inputs. A decision applies on the same edge the pipeline registers sample.
- Reset:
  - Scoreboard valid bits clear; FSM enters MEM_IDLE; stall_cnt is 0.
  - The first post-reset cycle gives all-zero outputs unless inputs dictate otherwise.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, its data is not yet available, and the dependent instruction in EX reads 10 from WB one cycle later. Only the stall is counted.
- A memory wait of N cycles (mem_ready low for N cycles) freezes the pipeline for exactly N cycles.
- Reset mid-wait aborts the wait immediately: the FSM returns to MEM_IDLE and freeze_pipe drops.

## Configuration
- FORWARDING_EN defined:
  - Forwarding selects are computed as above.
  - Only load-use hazards stall.
- FORWARDING_EN undefined:
  - fwd_sel_a and fwd_sel_b are tied to 00.
  - Any RAW against EX or MEM stalls. The register file writes in the first half-cycle, so WB needs no stall.
  - Scoreboard src fields are not kept.

## Structure
- Package pipe_ctrl_pkg holds:
  - the scoreboard entry struct;
  - FWD_RF, FWD_MEM and FWD_WB encodings;
  - the mem-FSM state enum.
- Sub-module pipe_scoreboard holds the three-entry shift register and its advance/bubble logic. Hazard, forwarding and FSM logic live in pipeline_hazard_ctrl.

## Test plan
- Load-use hazard:
  - Stimulus: load r2 in EX; ID reads r2 (src1=2, has_src1=1).
  - Response: freeze_front=1, flush_id_ex=1 for one cycle; stall_cnt 0→1.
  - Next cycle, with the dependent instruction in EX: fwd_sel_a=10.
- ALU back-to-back:
  - Stimulus: add to r3 in EX; ID reads r3.
  - Response with FORWARDING_EN: no stall, then fwd_sel_b=01.
  - Response without FORWARDING_EN: stall cycles until the add passes MEM.
- MEM vs. WB priority:
  - Stimulus: MEM and WB both write r5; EX reads r5.
  - Response: fwd_sel_a=01.
- Memory wait:
  - Stimulus: mem_access_req=1, mem_ready low for 3 cycles.
  - Response: freeze_pipe=1 for exactly 3 cycles; FSM in MEM_WAIT for cycles 2–3; pipeline contents unchanged afterwards.
- Branch during freeze:
  - Stimulus: exe_branch_taken=1 while freeze_pipe=1.
  - Response: no flush while frozen; flush_if_id=flush_id_ex=1 on the first unfrozen cycle.
- Branch during load-use:
  - Stimulus: exe_branch_taken=1 while a load-use hazard is present.
  - Response: flushes only; freeze_front=0; stall_cnt unchanged.
- Reset mid-wait:
  - Stimulus: rst pulsed during MEM_WAIT.
  - Response: all outputs 0; FSM in MEM_IDLE; stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, forwarding
// select encodings, memory-wait FSM states and small match helpers.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_r;
    logic [3:0] dest;
    logic [3:0] src1;
    logic       has1;
    logic [3:0] src2;
    logic       has2;
  } sb_entry_t;

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;

  function automatic logic src_match(input logic has, input logic [3:0] src,
                                     input logic [3:0] dest);
    return has && (src == dest);
  endfunction

  // MEM result is younger than WB, so it wins when both write the same register.
  function automatic logic [1:0] fwd_pick(input logic has, input logic [3:0] src,
                                          input sb_entry_t m, input sb_entry_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (has && m.valid && m.wb_en && (m.dest == src)) begin
      sel = FWD_MEM;
    end else if (has && w.valid && w.wb_en && (w.dest == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the core datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_has_src1;
  logic             id_has_src2;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic [3:0]       id_wb_dest;
  logic             exe_branch_taken;
  logic             mem_access_req;
  logic             mem_ready;
  logic             freeze_front;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_pipe;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_src1, id_src2, id_has_src1, id_has_src2, id_wb_en, id_mem_r_en,
           id_wb_dest, exe_branch_taken, mem_access_req, mem_ready,
    input  freeze_front, flush_if_id, flush_id_ex, freeze_pipe, fwd_sel_a,
           fwd_sel_b, stall_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_has_src1, id_has_src2, id_wb_en, id_mem_r_en,
           id_wb_dest, exe_branch_taken, mem_access_req, mem_ready,
    output freeze_front, flush_if_id, flush_id_ex, freeze_pipe, fwd_sel_a,
           fwd_sel_b, stall_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Shadow copy of the EX/MEM/WB instructions; shifts when advance=1, EX takes a bubble on flush.
// Source fields are only retained when FORWARDING_EN is defined.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      advance,
  input  logic      bubble,
  input  sb_entry_t id_entry,
  output sb_entry_t ex_entry,
  output sb_entry_t mem_entry,
  output sb_entry_t wb_entry
);

  sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_cap;

  always_comb begin
    id_cap = id_entry;
`ifndef FORWARDING_EN
    id_cap.src1 = '0;
    id_cap.has1 = 1'b0;
    id_cap.src2 = '0;
    id_cap.has2 = 1'b0;
`endif
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (advance) begin
      ex_d  = bubble ? '0 : id_cap;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifndef FORWARDING_EN
  logic src_unused;
  assign src_unused = ^{id_entry.src1, id_entry.has1, id_entry.src2, id_entry.has2};
`endif

  assign ex_entry  = ex_q;
  assign mem_entry = mem_q;
  assign wb_entry  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freeze/flush/forwarding decisions, combinational from scoreboard + inputs.
// FORWARDING_EN selects load-use-only stalls with EXE forwarding; otherwise any EX/MEM RAW stalls.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  sb_entry_t  id_entry, ex_entry, mem_entry, wb_entry;
  mem_state_e mem_state_q, mem_state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic freeze_pipe, freeze_front, flush_if_id, flush_id_ex;
  logic ex_hit, mem_hit, stall, stall_counted;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  always_comb begin
    id_entry       = '0;
    id_entry.valid = 1'b1;
    id_entry.wb_en = bus.id_wb_en;
    id_entry.mem_r = bus.id_mem_r_en;
    id_entry.dest  = bus.id_wb_dest;
    id_entry.src1  = bus.id_src1;
    id_entry.has1  = bus.id_has_src1;
    id_entry.src2  = bus.id_src2;
    id_entry.has2  = bus.id_has_src2;
  end

  pipe_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .advance   (~freeze_pipe),
    .bubble    (flush_id_ex),
    .id_entry  (id_entry),
    .ex_entry  (ex_entry),
    .mem_entry (mem_entry),
    .wb_entry  (wb_entry)
  );

  assign freeze_pipe = ~rst & bus.mem_access_req & ~bus.mem_ready;

  always_comb begin
    ex_hit  = ex_entry.valid & ex_entry.wb_en &
              (src_match(bus.id_has_src1, bus.id_src1, ex_entry.dest) |
               src_match(bus.id_has_src2, bus.id_src2, ex_entry.dest));
    mem_hit = mem_entry.valid & mem_entry.wb_en &
              (src_match(bus.id_has_src1, bus.id_src1, mem_entry.dest) |
               src_match(bus.id_has_src2, bus.id_src2, mem_entry.dest));
`ifdef FORWARDING_EN
    stall = ex_hit & ex_entry.mem_r;
`else
    stall = ex_hit | mem_hit;
`endif
  end

  // A taken branch kills the dependent instruction anyway, so it overrides the stall.
  always_comb begin
    freeze_front  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    stall_counted = 1'b0;
    if (rst) begin
      freeze_front = 1'b0;
    end else if (freeze_pipe) begin
      freeze_front = 1'b1;
    end else if (bus.exe_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (stall) begin
      freeze_front  = 1'b1;
      flush_id_ex   = 1'b1;
      stall_counted = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_counted && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_state_d = mem_state_q;
    case (mem_state_q)
      MEM_IDLE: if (bus.mem_access_req && !bus.mem_ready) mem_state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ready || !bus.mem_access_req) mem_state_d = MEM_IDLE;
      default:  mem_state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_state_q <= MEM_IDLE;
      stall_cnt_q <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    fwd_sel_a = FWD_RF;
    fwd_sel_b = FWD_RF;
`ifdef FORWARDING_EN
    if (!rst) begin
      fwd_sel_a = fwd_pick(ex_entry.has1, ex_entry.src1, mem_entry, wb_entry);
      fwd_sel_b = fwd_pick(ex_entry.has2, ex_entry.src2, mem_entry, wb_entry);
    end
`endif
  end

  logic sb_unused;
  assign sb_unused = ^{ex_entry, mem_entry, wb_entry, mem_hit};

  assign bus.freeze_front = freeze_front;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.freeze_pipe  = freeze_pipe;
  assign bus.fwd_sel_a    = fwd_sel_a;
  assign bus.fwd_sel_b    = fwd_sel_b;
  assign bus.stall_cnt    = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle vector table plus memory-wait,
// branch-under-freeze, counter saturation and reset-mid-wait sequences.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CW   = 3;
  localparam int CMAX = 7;

  logic clk;
  logic rst;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s1, h1, s2, h2, wb, mr, dst;
    int br, req, rdy;
    int ff, fif, fie, fp, fa, fb, cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input int s1, h1, s2, h2, wb, mr, dst,
                              input int br, req, rdy,
                              input int ff, fif, fie, fp, fa, fb, cnt);
    vec_t v;
    v = '{s1, h1, s2, h2, wb, mr, dst, br, req, rdy, ff, fif, fie, fp, fa, fb, cnt};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_src1          = v.s1[3:0];
    bus.id_has_src1      = v.h1[0];
    bus.id_src2          = v.s2[3:0];
    bus.id_has_src2      = v.h2[0];
    bus.id_wb_en         = v.wb[0];
    bus.id_mem_r_en      = v.mr[0];
    bus.id_wb_dest       = v.dst[3:0];
    bus.exe_branch_taken = v.br[0];
    bus.mem_access_req   = v.req[0];
    bus.mem_ready        = v.rdy[0];
  endtask

  // Apply one cycle of inputs, check mid-cycle, then cross the clock edge.
  task automatic run_row(input string tag, input vec_t v, input logic r);
    drive(v);
    rst = r;
    #3;
    chk({tag, ".freeze_front"}, int'(bus.freeze_front), v.ff);
    chk({tag, ".flush_if_id"},  int'(bus.flush_if_id),  v.fif);
    chk({tag, ".flush_id_ex"},  int'(bus.flush_id_ex),  v.fie);
    chk({tag, ".freeze_pipe"},  int'(bus.freeze_pipe),  v.fp);
    chk({tag, ".fwd_sel_a"},    int'(bus.fwd_sel_a),    v.fa);
    chk({tag, ".fwd_sel_b"},    int'(bus.fwd_sel_b),    v.fb);
    chk({tag, ".stall_cnt"},    int'(bus.stall_cnt),    v.cnt);
    @(posedge clk);
    #1;
    if (r) exp_cnt = 0;
    else if (v.ff == 1 && v.fie == 1) exp_cnt = (v.cnt < CMAX) ? v.cnt + 1 : CMAX;
    else exp_cnt = v.cnt;
  endtask

  task automatic chk_state(input string nm, input mem_state_e exp);
    chk(nm, int'(dut.mem_state_q), int'(exp));
  endtask

  // Once waiting, the requester must keep its access request up.
  always @(negedge clk) begin
    if (!rst && dut.mem_state_q == MEM_WAIT && !bus.mem_access_req) begin
      n_bad++;
      $display("FAIL protocol: mem_access_req dropped in MEM_WAIT");
    end
  end

  vec_t v;

  initial begin
    // Shared prefix: nop, load r2, then add r4<-r2 hits the load in EX.
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,2, 0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(mk(2,1,0,0,1,0,4, 0,0,0, 1,0,1,0, 0,0,0));
`ifdef FORWARDING_EN
    tbl.push_back(mk(2,1,0,0,1,0,4, 0,0,0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,3, 0,0,0, 0,0,0,0, 2,0,1));
    tbl.push_back(mk(0,0,3,1,1,0,6, 0,0,0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,5, 0,0,0, 0,0,0,0, 0,1,1));
    tbl.push_back(mk(0,0,0,0,1,0,5, 0,0,0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(5,1,5,0,1,0,7, 0,0,0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1,8, 0,0,0, 0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,8,1,1,0,9, 1,0,0, 0,1,1,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1));
`else
    tbl.push_back(mk(2,1,0,0,1,0,4, 0,0,0, 1,0,1,0, 0,0,1));
    tbl.push_back(mk(2,1,0,0,1,0,4, 0,0,0, 0,0,0,0, 0,0,2));
    tbl.push_back(mk(0,0,0,0,1,0,3, 0,0,0, 0,0,0,0, 0,0,2));
    tbl.push_back(mk(0,0,3,1,1,0,6, 0,0,0, 1,0,1,0, 0,0,2));
    tbl.push_back(mk(0,0,3,1,1,0,6, 0,0,0, 1,0,1,0, 0,0,3));
    tbl.push_back(mk(0,0,3,1,1,0,6, 0,0,0, 0,0,0,0, 0,0,4));
    tbl.push_back(mk(6,1,0,0,1,0,7, 1,0,0, 0,1,1,0, 0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,4));
`endif

    // Reset held with hostile inputs: everything must read zero.
    rst = 1'b1;
    drive(mk(2,1,2,1,1,1,2, 1,1,0, 0,0,0,0, 0,0,0));
    repeat (3) @(posedge clk);
    #4;
    chk("rst.freeze_front", int'(bus.freeze_front), 0);
    chk("rst.flush_if_id",  int'(bus.flush_if_id),  0);
    chk("rst.flush_id_ex",  int'(bus.flush_id_ex),  0);
    chk("rst.freeze_pipe",  int'(bus.freeze_pipe),  0);
    chk("rst.stall_cnt",    int'(bus.stall_cnt),    0);
    chk_state("rst.state", MEM_IDLE);
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i], 1'b0);

    // Memory wait of 3 cycles with a load r9 parked in EX and its consumer in ID.
    run_row("mw0", mk(0,0,0,0,1,1,9, 0,0,0, 0,0,0,0, 0,0,exp_cnt), 1'b0);
    v = mk(9,1,0,0,1,0,10, 0,1,0, 1,0,0,1, 0,0,exp_cnt);
    #3 chk_state("mw1.state", MEM_IDLE);
    #0 rst = 1'b0;
    run_row("mw1", v, 1'b0);
    v.cnt = exp_cnt;
    drive(v); #3 chk_state("mw2.state", MEM_WAIT);
    run_row("mw2", v, 1'b0);
    v.cnt = exp_cnt;
    drive(v); #3 chk_state("mw3.state", MEM_WAIT);
    run_row("mw3", v, 1'b0);
    // Ready arrives: freeze drops and the held load still stalls its consumer.
    v = mk(9,1,0,0,1,0,10, 0,1,1, 1,0,1,0, 0,0,exp_cnt);
    drive(v); #3 chk_state("mw4.state", MEM_WAIT);
    run_row("mw4", v, 1'b0);
    v = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,exp_cnt);
    drive(v); #3 chk_state("mw5.state", MEM_IDLE);
    run_row("mw5", v, 1'b0);

    // Branch taken while frozen: flush only once the freeze lifts.
    run_row("bf0", mk(0,0,0,0,0,0,0, 1,1,0, 1,0,0,1, 0,0,exp_cnt), 1'b0);
    run_row("bf1", mk(0,0,0,0,0,0,0, 1,1,0, 1,0,0,1, 0,0,exp_cnt), 1'b0);
    run_row("bf2", mk(0,0,0,0,0,0,0, 1,1,1, 0,1,1,0, 0,0,exp_cnt), 1'b0);
    run_row("bf3", mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,exp_cnt), 1'b0);

    // Ten single-cycle load-use stalls drive the 3-bit counter into saturation.
    for (int k = 0; k < 10; k++) begin
      run_row($sformatf("sat%0da", k), mk(0,0,0,0,1,1,10, 0,0,0, 0,0,0,0, 0,0,exp_cnt), 1'b0);
      run_row($sformatf("sat%0db", k), mk(10,1,0,0,1,0,11, 0,0,0, 1,0,1,0, 0,0,exp_cnt), 1'b0);
      run_row($sformatf("sat%0dc", k), mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,exp_cnt), 1'b0);
    end
    #3 chk("sat.final", int'(bus.stall_cnt), CMAX);

    // Reset pulsed mid-wait aborts the wait and clears the counter.
    run_row("rw0", mk(0,0,0,0,0,0,0, 0,1,0, 1,0,0,1, 0,0,CMAX), 1'b0);
    drive(mk(0,0,0,0,0,0,0, 0,1,0, 0,0,0,0, 0,0,0));
    #3 chk_state("rw1.state", MEM_WAIT);
    run_row("rw1", mk(0,0,0,0,0,0,0, 0,1,0, 0,0,0,0, 0,0,0), 1'b1);
    v = mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0);
    drive(v);
    rst = 1'b0;
    #3 chk_state("rw2.state", MEM_IDLE);
    run_row("rw2", v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
